sum_window_accumulator: RTL



---
 rtl/sum_window_accumulator_if.sv | 53 +++++
 rtl/sum_window_accumulator.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sum_window_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : sum_window_accumulator_if
// Brief    : Sample-in / window-result-out handshake bundle for
//            sum_window_accumulator. The master side produces samples and
//            consumes results; the slave side is the accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface sum_window_accumulator_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 10,
  parameter int CNT_W  = 8
);

  // Sample stream into the accumulator
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              flush;

  // Window result stream out of the accumulator
  logic [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data,
    output in_valid,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_count,
    input  out_ovf,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_count,
    output out_ovf,
    output out_valid
  );

endinterface
`default_nettype wire

// File: rtl/sum_window_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sum_window_accumulator
// Brief    : Accumulates WINDOW unsigned samples (or fewer on flush) into an
//            ACC_W-bit total and presents total, sample count and overflow
//            flag on a registered valid/ready output.
//            Optional build macro SUM_ACC_SATURATE_EN: on overflow the
//            accumulator clamps to all-ones for the rest of the window
//            instead of wrapping. Ports are identical in both builds.
// Revision : 1.0 - initial release
// ============================================================================
module sum_window_accumulator #(
  parameter int DATA_W = 8,
  parameter int WINDOW = 4,
  parameter int ACC_W  = 10,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  sum_window_accumulator_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [ACC_W-1:0] c_acc_max  = '1;

  // Window state
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_acc_q, ovf_acc_d;

  // Registered result
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;

  // Datapath for the sample being accepted this cycle
  logic             accept;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             ovf_new;
  logic [ACC_W-1:0] acc_new;
  logic [CNT_W-1:0] cnt_new;

  // Input is blocked while a result is pending; driven only from a flop
  assign bus.in_ready  = !out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_valid = out_valid_q;

  // Next-state: accumulate accepted samples and decide when to emit a result
  always_comb begin
    accept  = bus.in_valid && !out_valid_q;
    sum     = {1'b0, acc_q} + (ACC_W + 1)'(bus.in_data);
    carry   = sum[ACC_W];
    ovf_new = ovf_acc_q | carry;
`ifdef SUM_ACC_SATURATE_EN
    // Once the window has overflowed the total is pinned at full scale
    acc_new = ovf_new ? c_acc_max : sum[ACC_W-1:0];
`else
    acc_new = sum[ACC_W-1:0];
`endif
    cnt_new = cnt_q + c_cnt_one;

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_acc_d   = ovf_acc_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if ((cnt_q == c_last_cnt) || bus.flush) begin
        // Last sample of the window (or flushed with it): emit including it
        out_data_d  = acc_new;
        out_count_d = cnt_new;
        out_ovf_d   = ovf_new;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_acc_d   = 1'b0;
      end else begin
        acc_d     = acc_new;
        cnt_d     = cnt_new;
        ovf_acc_d = ovf_new;
      end
    end else if (bus.flush && !out_valid_q && (cnt_q != '0)) begin
      // Flush of a non-empty partial window with no sample this cycle
      out_data_d  = acc_q;
      out_count_d = cnt_q;
      out_ovf_d   = ovf_acc_q;
      out_valid_d = 1'b1;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_acc_d   = 1'b0;
    end
  end

  // State and result registers; reset discards any partial or pending window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_acc_q   <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_acc_q   <= ovf_acc_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
`default_nettype wire
